// File: rtl/itch_pkg.sv
// itch_pkg: ITCH 5.0 message codes, wire type chars, body lengths and encoder FSM states.
// Shared between the speculative decoders and the transmit-side encoder.
package itch_pkg;
    localparam logic [3:0] MT_ADD     = 4'd1;
    localparam logic [3:0] MT_CANCEL  = 4'd2;
    localparam logic [3:0] MT_DELETE  = 4'd3;
    localparam logic [3:0] MT_REPLACE = 4'd4;
    localparam logic [3:0] MT_EXEC    = 4'd5;
    localparam logic [7:0] CH_ADD     = 8'h41;
    localparam logic [7:0] CH_CANCEL  = 8'h58;
    localparam logic [7:0] CH_DELETE  = 8'h44;
    localparam logic [7:0] CH_REPLACE = 8'h55;
    localparam logic [7:0] CH_EXEC    = 8'h45;
    localparam logic [5:0] LEN_ADD     = 6'd36;
    localparam logic [5:0] LEN_CANCEL  = 6'd23;
    localparam logic [5:0] LEN_DELETE  = 6'd19;
    localparam logic [5:0] LEN_REPLACE = 6'd35;
    localparam logic [5:0] LEN_EXEC    = 6'd31;
    localparam logic [7:0] SIDE_BUY  = 8'h42;
    localparam logic [7:0] SIDE_SELL = 8'h53;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_BODY   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    typedef logic [2:0] state_t;
    typedef logic [287:0] image_t;
endpackage

// File: rtl/itch_msg_packer.sv
// itch_msg_packer: maps a decoded message onto its wire image, left-justified in 288 bits
// (first wire byte in [287:280]), plus body length and a supported-type flag.
module itch_msg_packer
    import itch_pkg::*;
(
    input  logic [3:0]  msg_type,
    input  logic [15:0] stock_locate,
    input  logic [15:0] tracking_num,
    input  logic [47:0] timestamp,
    input  logic [63:0] order_ref,
    input  logic [63:0] new_order_ref,
    input  logic        side,
    input  logic [31:0] shares,
    input  logic [31:0] price,
    input  logic [63:0] stock_symbol,
    input  logic [63:0] match_id,
    output image_t      image,
    output logic [5:0]  len,
    output logic        type_ok
);
    logic [79:0] hdr;
    logic [7:0]  side_ch;
    assign hdr = {stock_locate, tracking_num, timestamp};
    assign side_ch = side ? SIDE_BUY : SIDE_SELL;
    always_comb begin
        image = '0;
        len = '0;
        type_ok = 1'b1;
        case (msg_type)
            MT_ADD: begin
                image = {CH_ADD, hdr, order_ref, side_ch, shares, stock_symbol, price};
                len = LEN_ADD;
            end
            MT_CANCEL: begin
                image = {CH_CANCEL, hdr, order_ref, shares, 104'd0};
                len = LEN_CANCEL;
            end
            MT_DELETE: begin
                image = {CH_DELETE, hdr, order_ref, 136'd0};
                len = LEN_DELETE;
            end
            MT_REPLACE: begin
                image = {CH_REPLACE, hdr, order_ref, new_order_ref, shares, price, 8'd0};
                len = LEN_REPLACE;
            end
            MT_EXEC: begin
                image = {CH_EXEC, hdr, order_ref, shares, match_id, 40'd0};
                len = LEN_EXEC;
            end
            default: type_ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/itch_message_encoder.sv
// itch_message_encoder: serializes one decoded ITCH message per request, one byte per cycle, big-endian.
// Define ITCH_ENC_LEN_PREFIX_EN to precede each message with a 2-byte big-endian body length.
module itch_message_encoder
    import itch_pkg::*;
#(
    parameter int IDLE_GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [3:0]  msg_type,
    input  logic [15:0] stock_locate,
    input  logic [15:0] tracking_num,
    input  logic [47:0] timestamp,
    input  logic [63:0] order_ref,
    input  logic [63:0] new_order_ref,
    input  logic        side,
    input  logic [31:0] shares,
    input  logic [31:0] price,
    input  logic [63:0] stock_symbol,
    input  logic [63:0] match_id,
    output logic [7:0]  byte_out,
    output logic        valid_out,
    input  logic        byte_ready,
    output logic        sop,
    output logic        eop,
    output logic        msg_err
);
    localparam logic [3:0] GAP_INIT = 4'(IDLE_GAP > 0 ? IDLE_GAP - 1 : 0);
    image_t     image, img;
    logic [5:0] len_c, len, idx;
    logic       type_ok, advance, last_hs, accept;
    state_t     state;
    logic [3:0] gap_cnt;
    itch_msg_packer u_packer (
        .msg_type      (msg_type),
        .stock_locate  (stock_locate),
        .tracking_num  (tracking_num),
        .timestamp     (timestamp),
        .order_ref     (order_ref),
        .new_order_ref (new_order_ref),
        .side          (side),
        .shares        (shares),
        .price         (price),
        .stock_symbol  (stock_symbol),
        .match_id      (match_id),
        .image         (image),
        .len           (len_c),
        .type_ok       (type_ok)
    );
    assign advance = valid_out && byte_ready;
    assign last_hs = state == ST_BODY && advance && eop;
    // With no gap the next request is taken in the same cycle the last byte leaves.
    assign msg_ready = !rst && (state == ST_IDLE || (IDLE_GAP == 0 && last_hs));
    assign accept = msg_valid && msg_ready;
    // img shifts left as bytes leave, so the next byte is always in the top lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            img <= '0;
            len <= '0;
            idx <= '0;
            gap_cnt <= '0;
            byte_out <= '0;
            valid_out <= 1'b0;
            sop <= 1'b0;
            eop <= 1'b0;
            msg_err <= 1'b0;
        end else begin
            msg_err <= accept && !type_ok;
            if (accept && type_ok) begin
                len <= len_c;
                idx <= '0;
                valid_out <= 1'b1;
                sop <= 1'b1;
                eop <= 1'b0;
`ifdef ITCH_ENC_LEN_PREFIX_EN
                state <= ST_LEN_HI;
                img <= image;
                byte_out <= 8'h00;
`else
                state <= ST_BODY;
                img <= image << 8;
                byte_out <= image[287:280];
`endif
            end else if (advance) begin
                sop <= 1'b0;
                case (state)
                    ST_LEN_HI: begin
                        state <= ST_LEN_LO;
                        byte_out <= {2'b00, len};
                    end
                    ST_LEN_LO: begin
                        state <= ST_BODY;
                        byte_out <= img[287:280];
                        img <= img << 8;
                    end
                    ST_BODY: begin
                        if (eop) begin
                            valid_out <= 1'b0;
                            eop <= 1'b0;
                            state <= IDLE_GAP > 0 ? ST_GAP : ST_IDLE;
                            gap_cnt <= GAP_INIT;
                        end else begin
                            idx <= idx + 6'd1;
                            byte_out <= img[287:280];
                            img <= img << 8;
                            eop <= idx + 6'd2 == len;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state == ST_GAP) begin
                state <= gap_cnt == '0 ? ST_IDLE : ST_GAP;
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end
endmodule
